// File: rtl/noc_serial_transmitter_pkg.sv
// Shared NoC flit definitions: flit types, header layout and header builder.
`ifndef FLIT_DATA_WIDTH
`define FLIT_DATA_WIDTH 8
`endif

package noc_serial_transmitter_pkg;

    localparam int unsigned FLIT_W     = `FLIT_DATA_WIDTH;
    localparam int unsigned HDR_DST_W  = 4;
    localparam int unsigned HDR_FREE_W = FLIT_W - HDR_DST_W;

    typedef enum logic [1:0] {
        FLIT_HEADER = 2'd0,
        FLIT_DATA   = 2'd1,
        FLIT_TAIL   = 2'd2
    } flit_type_e;

    typedef struct packed {
        logic [HDR_DST_W-1:0]  dst;
        logic [HDR_FREE_W-1:0] free;
    } flit_hdr_t;

    typedef union packed {
        flit_hdr_t         hdr;
        logic [FLIT_W-1:0] data;
    } flit_payload_t;

    typedef struct packed {
        flit_type_e    flit_type;
        flit_payload_t payload;
    } flit_t;

    // Single place where header fields are assembled, shared by all endpoints.
    function automatic flit_hdr_t make_hdr(input logic [HDR_DST_W-1:0]  dst,
                                           input logic [HDR_FREE_W-1:0] free);
        flit_hdr_t h;
        h      = '0;
        h.dst  = dst;
        h.free = free;
        return h;
    endfunction

endpackage

// File: rtl/node_port.sv
// Valid/ack flit link between a NoC endpoint and a router port.
interface node_port;
    import noc_serial_transmitter_pkg::*;

    logic  enable;
    flit_t flit;
    logic  ack;

    modport up   (output enable, output flit, input ack);
    modport down (input enable, input flit, output ack);
endinterface

// File: rtl/noc_serial_transmitter.sv
// Serialises one captured packet into a HEADER flit followed by payload flits
// (last one tagged TAIL) on a node port.
module noc_serial_transmitter
    import noc_serial_transmitter_pkg::*;
#(
    parameter int unsigned PACKET_BITS  = 16,
    parameter int unsigned PADDING_BITS = 0,
    parameter int unsigned DST_BITS     = 4
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            send,
    input  logic                                            abort,
    input  logic [DST_BITS-1:0]                             dst,
    input  logic [(PADDING_BITS > 0 ? PADDING_BITS : 1)-1:0] padding,
    input  logic [PACKET_BITS-1:0]                          packet,
    output logic                                            ready,
    output logic                                            done,
    node_port.up                                            up
);

    localparam int unsigned FW      = FLIT_W;
    localparam int unsigned N_FLITS = (PACKET_BITS + FW - 1) / FW;
    localparam int unsigned CNT_W   = (N_FLITS > 1) ? $clog2(N_FLITS) : 1;
    localparam int unsigned PKT_W   = N_FLITS * FW;
    localparam int unsigned PAD_W   = (PADDING_BITS > 0) ? PADDING_BITS : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_PAY  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [PKT_W-1:0]     pkt_q;
    logic [PAD_W-1:0]     pad_q;
    logic [DST_BITS-1:0]  dst_q;
    logic                 ready_q, done_q, done_d;
    logic                 capture_c;
    logic                 last_c;
    logic                 enable_c;
    flit_t                flit_c;
    logic [HDR_FREE_W-1:0] free_c;
    logic [FW-1:0]        slice_c;

    assign last_c  = (cnt_q == CNT_W'(N_FLITS - 1));
    assign free_c  = (PADDING_BITS == 0) ? '0 : HDR_FREE_W'(pad_q);
    assign slice_c = FW'(pkt_q >> (FW * 32'(cnt_q)));

    // State and counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == S_IDLE);
            done_q  <= done_d;
        end
    end

    // Frame capture; packet is zero-extended so the last flit's spare bits are 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_q <= '0;
            pad_q <= '0;
            dst_q <= '0;
        end else if (capture_c) begin
            pkt_q <= PKT_W'(packet);
            pad_q <= padding;
            dst_q <= dst;
        end
    end

    // Next-state and flit decode; flit depends only on registered state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        capture_c = 1'b0;
        done_d    = 1'b0;
        enable_c  = 1'b0;
        flit_c    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (send && !abort) begin
                    capture_c = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_HDR;
                end
            end
            S_HDR: begin
                enable_c           = 1'b1;
                flit_c.flit_type   = FLIT_HEADER;
                flit_c.payload.hdr = make_hdr(HDR_DST_W'(dst_q), free_c);
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (up.ack) begin
                    state_d = S_PAY;
                end
            end
            S_PAY: begin
                enable_c            = 1'b1;
                flit_c.flit_type    = last_c ? FLIT_TAIL : FLIT_DATA;
                flit_c.payload.data = slice_c;
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (up.ack) begin
                    if (last_c) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign up.enable = enable_c;
    assign up.flit   = flit_c;
    assign ready     = ready_q;
    assign done      = done_q;

endmodule

// File: tb/tb_noc_serial_transmitter.sv
// Directed and randomised checks of the serial transmitter on three packet widths.
module tb_noc_serial_transmitter;
    import noc_serial_transmitter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  dst = 4'h0;
    logic [2:0]  padding = 3'b000;
    logic        send_a = 1'b0, send_b = 1'b0, send_c = 1'b0;
    logic [15:0] pkt_a = '0;
    logic [11:0] pkt_b = '0;
    logic [7:0]  pkt_c = '0;
    logic        ready_a, ready_b, ready_c;
    logic        done_a, done_b, done_c;

    int n_tests = 0;
    int n_fail  = 0;

    node_port pa ();
    node_port pb ();
    node_port pc ();

    noc_serial_transmitter #(.PACKET_BITS(16), .PADDING_BITS(3), .DST_BITS(4)) u_dut_a (
        .clk(clk), .rst(rst), .send(send_a), .abort(abort), .dst(dst),
        .padding(padding), .packet(pkt_a), .ready(ready_a), .done(done_a), .up(pa));

    noc_serial_transmitter #(.PACKET_BITS(12), .PADDING_BITS(3), .DST_BITS(4)) u_dut_b (
        .clk(clk), .rst(rst), .send(send_b), .abort(abort), .dst(dst),
        .padding(padding), .packet(pkt_b), .ready(ready_b), .done(done_b), .up(pb));

    noc_serial_transmitter #(.PACKET_BITS(8), .PADDING_BITS(0), .DST_BITS(4)) u_dut_c (
        .clk(clk), .rst(rst), .send(send_c), .abort(abort), .dst(dst),
        .padding(padding[0:0]), .packet(pkt_c), .ready(ready_c), .done(done_c), .up(pc));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Compares {enable, flit_type, payload} of the selected port.
    task automatic chk_flit(input string tag, input int port, input logic en,
                            input flit_type_e t, input logic [7:0] d);
        logic [10:0] obs;
        logic [10:0] exp;
        case (port)
            0:       obs = {pa.enable, pa.flit};
            1:       obs = {pb.enable, pb.flit};
            default: obs = {pc.enable, pc.flit};
        endcase
        exp = {en, 2'(t), d};
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    logic [15:0] exp16;
    logic [15:0] got16;
    int          idx;
    logic        seen_done;
    logic        ack_r;

    initial begin
        pa.ack = 1'b1;
        pb.ack = 1'b1;
        pc.ack = 1'b1;

        // Reset state
        rst = 1'b1;
        #12;
        chk_bit("rst ready", ready_a, 1'b1);
        chk_bit("rst done", done_a, 1'b0);
        chk_flit("rst flit", 0, 1'b0, FLIT_HEADER, 8'h00);
        rst = 1'b0;
        tick();

        // Basic frame: header dst=6 free=5 -> 8'h65
        pkt_a = 16'hBEEF; padding = 3'b101; dst = 4'h6; send_a = 1'b1;
        tick();
        send_a = 1'b0; pkt_a = 16'h0000;
        chk_flit("t1 hdr", 0, 1'b1, FLIT_HEADER, 8'h65);
        chk_bit("t1 ready0", ready_a, 1'b0);
        tick();
        chk_flit("t1 data", 0, 1'b1, FLIT_DATA, 8'hEF);
        chk_bit("t1 ready1", ready_a, 1'b0);
        tick();
        chk_flit("t1 tail", 0, 1'b1, FLIT_TAIL, 8'hBE);
        chk_bit("t1 ready2", ready_a, 1'b0);
        chk_bit("t1 done early", done_a, 1'b0);
        tick();
        chk_flit("t1 idle", 0, 1'b0, FLIT_HEADER, 8'h00);
        chk_bit("t1 done", done_a, 1'b1);
        chk_bit("t1 ready back", ready_a, 1'b1);
        tick();
        chk_bit("t1 done pulse", done_a, 1'b0);

        // Backpressure on the DATA flit
        pkt_a = 16'hBEEF; send_a = 1'b1;
        tick();
        send_a = 1'b0;
        chk_flit("t2 hdr", 0, 1'b1, FLIT_HEADER, 8'h65);
        tick();
        chk_flit("t2 data", 0, 1'b1, FLIT_DATA, 8'hEF);
        pa.ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_flit("t2 hold", 0, 1'b1, FLIT_DATA, 8'hEF);
        end
        pa.ack = 1'b1;
        tick();
        chk_flit("t2 tail", 0, 1'b1, FLIT_TAIL, 8'hBE);
        tick();
        chk_bit("t2 done", done_a, 1'b1);

        // Partial last flit, 12-bit packet
        pkt_b = 12'hABC; send_b = 1'b1;
        tick();
        send_b = 1'b0;
        chk_flit("t3 hdr", 1, 1'b1, FLIT_HEADER, 8'h65);
        tick();
        chk_flit("t3 data", 1, 1'b1, FLIT_DATA, 8'hBC);
        tick();
        chk_flit("t3 tail", 1, 1'b1, FLIT_TAIL, 8'h0A);
        tick();
        chk_bit("t3 done", done_b, 1'b1);

        // Single-flit packet, no padding: header free field is 0
        pkt_c = 8'h9D; send_c = 1'b1;
        tick();
        send_c = 1'b0;
        chk_flit("n1 hdr", 2, 1'b1, FLIT_HEADER, 8'h60);
        tick();
        chk_flit("n1 tail", 2, 1'b1, FLIT_TAIL, 8'h9D);
        tick();
        chk_bit("n1 done", done_c, 1'b1);
        chk_flit("n1 idle", 2, 1'b0, FLIT_HEADER, 8'h00);

        // Abort during TAIL with ack low
        pkt_a = 16'h5A5A; send_a = 1'b1;
        tick();
        send_a = 1'b0;
        tick();
        chk_flit("t4 data", 0, 1'b1, FLIT_DATA, 8'h5A);
        tick();
        chk_flit("t4 tail", 0, 1'b1, FLIT_TAIL, 8'h5A);
        pa.ack = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0; pa.ack = 1'b1;
        chk_flit("t4 aborted", 0, 1'b0, FLIT_HEADER, 8'h00);
        chk_bit("t4 ready", ready_a, 1'b1);
        chk_bit("t4 no done", done_a, 1'b0);
        tick();
        chk_bit("t4 no done2", done_a, 1'b0);
        pkt_a = 16'h1234; send_a = 1'b1;
        tick();
        send_a = 1'b0;
        chk_flit("t4 hdr", 0, 1'b1, FLIT_HEADER, 8'h65);
        tick();
        chk_flit("t4 data2", 0, 1'b1, FLIT_DATA, 8'h34);
        tick();
        chk_flit("t4 tail2", 0, 1'b1, FLIT_TAIL, 8'h12);
        tick();
        chk_bit("t4 done2", done_a, 1'b1);

        // send with abort in IDLE is dropped
        send_a = 1'b1; abort = 1'b1;
        tick();
        send_a = 1'b0; abort = 1'b0;
        chk_flit("t5 no tx", 0, 1'b0, FLIT_HEADER, 8'h00);
        chk_bit("t5 ready", ready_a, 1'b1);

        // send held high: one frame, inputs changed after capture, then a second frame
        pkt_a = 16'hCAFE; send_a = 1'b1;
        tick();
        pkt_a = 16'h0102;
        chk_flit("t5 hdr1", 0, 1'b1, FLIT_HEADER, 8'h65);
        tick();
        chk_flit("t5 data1", 0, 1'b1, FLIT_DATA, 8'hFE);
        tick();
        chk_flit("t5 tail1", 0, 1'b1, FLIT_TAIL, 8'hCA);
        tick();
        chk_bit("t5 done1", done_a, 1'b1);
        chk_flit("t5 gap", 0, 1'b0, FLIT_HEADER, 8'h00);
        tick();
        send_a = 1'b0;
        chk_flit("t5 hdr2", 0, 1'b1, FLIT_HEADER, 8'h65);
        tick();
        chk_flit("t5 data2", 0, 1'b1, FLIT_DATA, 8'h02);
        tick();
        chk_flit("t5 tail2", 0, 1'b1, FLIT_TAIL, 8'h01);
        tick();
        chk_bit("t5 done2", done_a, 1'b1);
        tick();
        chk_flit("t5 no third", 0, 1'b0, FLIT_HEADER, 8'h00);

        // Async reset mid-PAY
        pkt_a = 16'h7788; send_a = 1'b1;
        tick();
        send_a = 1'b0;
        tick();
        chk_flit("t6 data", 0, 1'b1, FLIT_DATA, 8'h88);
        #2;
        rst = 1'b1;
        #1;
        chk_flit("t6 async drop", 0, 1'b0, FLIT_HEADER, 8'h00);
        chk_bit("t6 ready", ready_a, 1'b1);
        chk_bit("t6 no done", done_a, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        tick();
        chk_bit("t6 ready after", ready_a, 1'b1);
        pkt_a = 16'h4321; send_a = 1'b1;
        tick();
        send_a = 1'b0;
        chk_flit("t6 hdr", 0, 1'b1, FLIT_HEADER, 8'h65);
        tick();
        chk_flit("t6 data2", 0, 1'b1, FLIT_DATA, 8'h21);
        tick();
        chk_flit("t6 tail", 0, 1'b1, FLIT_TAIL, 8'h43);
        tick();
        chk_bit("t6 done", done_a, 1'b1);

        // Random packets with random ack, reassembled by a receiver model
        for (int n = 0; n < 100; n++) begin
            exp16 = 16'($urandom);
            pkt_a = exp16; pa.ack = 1'b1; send_a = 1'b1;
            tick();
            send_a = 1'b0; pkt_a = 16'($urandom);
            got16 = '0; idx = 0; seen_done = 1'b0;
            for (int c = 0; c < 60 && !seen_done; c++) begin
                if (done_a) begin
                    seen_done = 1'b1;
                end else begin
                    ack_r = 1'($urandom_range(0, 1));
                    pa.ack = ack_r;
                    if (pa.enable && ack_r) begin
                        if (idx == 1) got16[7:0]  = pa.flit.payload.data;
                        if (idx == 2) got16[15:8] = pa.flit.payload.data;
                        idx++;
                    end
                    tick();
                end
            end
            chk16("rand packet", got16, exp16);
            chk_bit("rand done", seen_done, 1'b1);
            chk_bit("rand flit count", idx == 3, 1'b1);
        end
        pa.ack = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
